// File: rtl/pattern_event_logger.sv
// Timestamps detector strobes into a small FWFT FIFO with a valid/ready drain
// port and saturating event/drop counters. Optional gap storage: PATTERN_EVENT_GAP_EN.
module pattern_event_logger #(
    parameter int DEPTH     = 8,
    parameter int TS_WIDTH  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pattern,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_WIDTH-1:0]    out_timestamp,
    output logic [TS_WIDTH-1:0]    out_gap,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_WIDTH-1:0]   total_count,
    output logic [CNT_WIDTH-1:0]   drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_WIDTH-1:0] cycle_cnt;
    logic [TS_WIDTH-1:0] ts_mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_nxt;
    logic                pop, push, drop;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = pattern && (!full || pop);
    assign drop      = pattern && full && !pop;

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + LW'(1);
        else if (pop && !push)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            total_count <= '0;
            drop_count  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
            if (pattern && total_count != '1)
                total_count <= total_count + CNT_WIDTH'(1);
            if (drop && drop_count != '1)
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push)
            ts_mem[wr_ptr] <= cycle_cnt;
    end

    // Head is gated so stale storage never shows on an empty port.
    assign out_timestamp = out_valid ? ts_mem[rd_ptr] : '0;

`ifdef PATTERN_EVENT_GAP_EN
    logic [TS_WIDTH-1:0] gap_mem [DEPTH];
    logic [TS_WIDTH-1:0] prev_ts;
    logic [TS_WIDTH-1:0] gap_new;
    logic                seen;

    // Dropped events still advance the reference point.
    assign gap_new = seen ? (cycle_cnt - prev_ts) : '1;

    always_ff @(posedge clock) begin
        if (reset) begin
            seen    <= 1'b0;
            prev_ts <= '0;
        end else if (pattern) begin
            seen    <= 1'b1;
            prev_ts <= cycle_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push)
            gap_mem[wr_ptr] <= gap_new;
    end

    assign out_gap = out_valid ? gap_mem[rd_ptr] : '0;
`else
    assign out_gap = '0;
`endif

endmodule

// File: tb/tb_pattern_event_logger.sv
// Table-driven bench for pattern_event_logger with a timestamp/gap scoreboard,
// plus a narrow-width instance for wrap and saturation corners.
module tb_pattern_event_logger;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1, pattern = 1'b0, out_ready = 1'b0;
    logic        out_valid, full, empty;
    logic [15:0] out_timestamp, out_gap;
    logic [3:0]  level;
    logic [7:0]  total_count, drop_count;

    logic        s_reset = 1'b0, s_pattern = 1'b0, s_out_ready = 1'b0;
    logic        s_out_valid, s_full, s_empty;
    logic [3:0]  s_ts, s_gap, s_total, s_drop;
    logic [2:0]  s_level;

    always #5 clock = ~clock;

    pattern_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .pattern(pattern),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_timestamp(out_timestamp), .out_gap(out_gap),
        .level(level), .full(full), .empty(empty),
        .total_count(total_count), .drop_count(drop_count)
    );

    pattern_event_logger #(.DEPTH(4), .TS_WIDTH(4), .CNT_WIDTH(4)) dut_s (
        .clock(clock), .reset(s_reset), .pattern(s_pattern),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_timestamp(s_ts), .out_gap(s_gap),
        .level(s_level), .full(s_full), .empty(s_empty),
        .total_count(s_total), .drop_count(s_drop)
    );

    typedef struct {
        logic rst, pat, rdy;
        int   lvl, tot, drp;
    } vec_t;

    typedef struct {
        logic [15:0] ts, gap;
    } ent_t;

    vec_t vecs[$];
    ent_t sb[$];
    int   n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic r, p, y, input int l, t, d);
        vec_t v;
        v.rst = r; v.pat = p; v.rdy = y; v.lvl = l; v.tot = t; v.drp = d;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] tcnt = '0, prev = '0;
        logic        first = 1'b1, mpop, mfull;
        ent_t        e;

        // Scenario 1: events at counter 5 and 9, then drain.
        add(1,0,0, 0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0, 0,0,0);
        add(0,1,0, 1,1,0);
        for (int i = 0; i < 3; i++) add(0,0,0, 1,1,0);
        add(0,1,0, 2,2,0);
        add(0,0,1, 1,2,0);
        add(0,0,1, 0,2,0);
        add(0,0,1, 0,2,0);
        // Scenario 2: ten back-to-back events into 8 slots.
        for (int i = 0; i < 10; i++)
            add(0,1,0, (i < 8) ? i+1 : 8, 3+i, (i < 8) ? 0 : i-7);
        // Scenario 3: push and pop while full.
        add(0,1,1, 8,13,2);
        for (int i = 0; i < 8; i++) add(0,0,1, 7-i,13,2);
        // Scenario 5: reset with three queued and pattern high.
        for (int i = 0; i < 3; i++) add(0,1,0, i+1,14+i,2);
        add(1,1,0, 0,0,0);
        add(0,0,0, 0,0,0);
        add(0,1,0, 1,1,0);
        add(0,0,1, 0,1,0);
        // Scenario 6: events at counter 3 and 10 for gap.
        add(1,0,0, 0,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0, 0,0,0);
        add(0,1,0, 1,1,0);
        for (int i = 0; i < 6; i++) add(0,0,0, 1,1,0);
        add(0,1,0, 2,2,0);
        add(0,0,1, 1,2,0);
        add(0,0,1, 0,2,0);

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst; pattern = vecs[i].pat; out_ready = vecs[i].rdy;
            if (i > 0) begin
                chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(sb.size() > 0));
                if (out_valid && sb.size() > 0) begin
                    chk($sformatf("v%0d out_timestamp", i), int'(out_timestamp), int'(sb[0].ts));
                    chk($sformatf("v%0d out_gap", i), int'(out_gap), int'(sb[0].gap));
                end
            end
            if (vecs[i].rst) begin
                sb.delete(); tcnt = '0; first = 1'b1;
            end else begin
                mpop  = (sb.size() > 0) && vecs[i].rdy;
                mfull = (sb.size() == DEPTH);
                if (mpop) void'(sb.pop_front());
                if (vecs[i].pat) begin
`ifdef PATTERN_EVENT_GAP_EN
                    e.gap = first ? 16'hFFFF : tcnt - prev;
`else
                    e.gap = 16'h0;
`endif
                    e.ts = tcnt; prev = tcnt; first = 1'b0;
                    if (!mfull || mpop) sb.push_back(e);
                end
                tcnt = tcnt + 16'd1;
            end
            @(posedge clock); #1;
            chk($sformatf("v%0d level", i), int'(level), vecs[i].lvl);
            chk($sformatf("v%0d total_count", i), int'(total_count), vecs[i].tot);
            chk($sformatf("v%0d drop_count", i), int'(drop_count), vecs[i].drp);
            chk($sformatf("v%0d full", i), int'(full), int'(vecs[i].lvl == DEPTH));
            chk($sformatf("v%0d empty", i), int'(empty), int'(vecs[i].lvl == 0));
            if (vecs[i].rst) begin
                chk($sformatf("v%0d rst out_valid", i), int'(out_valid), 0);
                chk($sformatf("v%0d rst out_timestamp", i), int'(out_timestamp), 0);
                chk($sformatf("v%0d rst out_gap", i), int'(out_gap), 0);
            end
        end
        @(negedge clock);
        reset = 1'b0; pattern = 1'b0; out_ready = 1'b0;

        // Narrow instance: 4-bit timestamp wrap at counter 17.
        s_reset = 1'b1;
        @(negedge clock); s_reset = 1'b0;
        repeat (17) @(negedge clock);
        s_pattern = 1'b1;
        @(negedge clock); s_pattern = 1'b0;
        chk("wrap out_valid", int'(s_out_valid), 1);
        chk("wrap out_timestamp", int'(s_ts), 1);
        chk("wrap level", int'(s_level), 1);
        s_out_ready = 1'b1;
        @(negedge clock);
        chk("wrap pop empty", int'(s_empty), 1);

        // 20 events with ready high: total saturates, nothing dropped.
        s_reset = 1'b1;
        @(negedge clock); s_reset = 1'b0; s_pattern = 1'b1;
        repeat (20) @(negedge clock);
        s_pattern = 1'b0;
        @(negedge clock);
        chk("sat total_count", int'(s_total), 15);
        chk("sat drop_count", int'(s_drop), 0);
        chk("sat empty", int'(s_empty), 1);

        // 30 events with ready low: both counters saturate, FIFO full.
        s_reset = 1'b1; s_out_ready = 1'b0;
        @(negedge clock); s_reset = 1'b0; s_pattern = 1'b1;
        repeat (30) @(negedge clock);
        s_pattern = 1'b0;
        chk("drop sat total_count", int'(s_total), 15);
        chk("drop sat drop_count", int'(s_drop), 15);
        chk("drop sat level", int'(s_level), 4);
        chk("drop sat full", int'(s_full), 1);
        chk("drop sat head", int'(s_ts), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_event_logger.md
Name: pattern_event_logger

Overview:
- Downstream consumer of the 1094 sequence detector's `pattern` output.
- Timestamps every detection against a free-running cycle counter and buffers the timestamps in a small first-word-fall-through FIFO.
- A valid/ready read port lets a host or UART stage drain the events.
- Keeps saturating counters of total detections and of events dropped on overflow.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- TS_WIDTH, 16: timestamp/cycle-counter width.
- CNT_WIDTH, 8: width of total_count and drop_count.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pattern  input  1  detection strobe from the detector; each cycle high is one event.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_timestamp  output  TS_WIDTH  timestamp of head entry.
- out_gap  output  TS_WIDTH  cycles since the previous event (see Optional Feature).
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- total_count  output  CNT_WIDTH  events seen, including dropped ones; saturating.
- drop_count  output  CNT_WIDTH  events lost because the FIFO was full; saturating.

Behaviour:
- Reset (sampled at rising edge with reset=1):
  - cycle counter, pointers, level, total_count and drop_count cleared to 0.
  - out_valid=0, full=0, empty=1, out_timestamp=0, out_gap=0.
  - FIFO contents discarded.
  - pattern is ignored while reset=1.
- Cycle counter:
  - 0 at the first rising edge with reset=0, then +1 every cycle.
  - Wraps modulo 2^TS_WIDTH.
- Event capture:
  - At a rising edge with pattern=1, the event timestamp is the counter value at that edge, before the increment.
- Push/pop decisions (per edge):
  - pop = out_valid && out_ready.
  - push = pattern && (!full || pop).
  - Simultaneous push and pop while full: both take effect; level stays DEPTH; no drop.
  - Simultaneous push and pop with 0 < level < DEPTH: level unchanged.
  - pattern && full && !pop: event dropped; drop_count+1, saturating at 2^CNT_WIDTH-1.
- Counting:
  - total_count increments on every event, pushed or dropped, and saturates.
- Latency and FWFT behaviour:
  - A push into an empty FIFO drives out_valid=1 and out_timestamp valid in the next cycle.
  - out_timestamp and out_gap always reflect the head entry and are stable while out_valid && !out_ready.
- Read port rules:
  - out_ready is ignored when out_valid=0.
  - out_valid never drops without a pop or a reset.
- Status flags:
  - level, full and empty are registered.
  - They reflect the state after the current edge's push/pop.
- Pointers:
  - log2(DEPTH) bits each, wrapping naturally.
  - level tracks occupancy, so full and empty are unambiguous.
- Reset mid-operation:
  - Takes priority over any push or pop on the same edge.
  - All state is cleared as described above.

Optional Feature:
- Macro: PATTERN_EVENT_GAP_EN.
- Defined:
  - Each entry also stores the gap: the counter value at the event minus the counter value at the previous event (accepted or dropped), modulo 2^TS_WIDTH.
  - The first event after reset stores gap = all ones.
  - out_gap presents the head entry's gap.
- Undefined:
  - No gap storage is built.
  - out_gap is tied to 0.

Test Plan:
1. Reset, then pattern=1 at counter values 5 and 9, out_ready=0 -> out_valid=1 from counter 6, out_timestamp=5, level=2 after counter 9. Then out_ready=1 -> pops 5, then 9; empty=1.
2. DEPTH=8, pattern=1 for 10 consecutive cycles, out_ready=0 -> full=1 after the 8th event, level=8, total_count=10, drop_count=2, head out_timestamp = first event's timestamp.
3. FIFO full, out_ready=1 and pattern=1 on the same edge -> oldest entry popped, new entry pushed, level stays 8, drop_count unchanged, total_count+1.
4. TS_WIDTH=4, single event at counter cycle 17 after reset -> out_timestamp=1 (wrap). CNT_WIDTH=4 with 20 events and out_ready=1 -> total_count=15 (saturated), drop_count=0.
5. 3 entries queued, reset held 1 cycle with pattern=1 -> next cycle out_valid=0, level=0, empty=1, total_count=0, drop_count=0. Event 2 cycles later gets timestamp 1.
6. With PATTERN_EVENT_GAP_EN, events at counter 3 and 10 -> first entry out_gap=16'hFFFF, second out_gap=7. Without the macro -> out_gap=0 throughout.
